// File: rtl/ad7276_pkg.sv
// ----------------------------------------------------------------------------
// ad7276_pkg
// Shared definitions for the AD7276 serial ADC emulator.
//   state_t       : frame sequencer states (IDLE, LEAD, DATA, TAIL)
//   AD7276_DATA_W : default sample width (12 bits)
//   AD7276_LEAD_Z : default number of leading-zero bit slots (2)
//   FRAME_SCLK    : sclk periods in one standard frame (16)
// ----------------------------------------------------------------------------
package ad7276_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        DATA = 2'd2,
        TAIL = 2'd3
    } state_t;

    localparam int AD7276_DATA_W = 12;
    localparam int AD7276_LEAD_Z = 2;
    localparam int FRAME_SCLK    = 16;

endpackage

// File: rtl/ad7276_emu_fifo.sv
// ----------------------------------------------------------------------------
// ad7276_emu_fifo
// Synchronous sample buffer with show-ahead read (rd_data is the head entry).
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (pointers only)
//   wr_en, wr_data : push request and data; ignored while full
//   rd_en          : pop request; ignored while empty
//   rd_data        : current head entry (valid when empty = 0)
//   full, empty    : occupancy flags
// DEPTH must be a power of two, at least 2.
// ----------------------------------------------------------------------------
module ad7276_emu_fifo #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; only the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ad7276_emu.sv
// ----------------------------------------------------------------------------
// ad7276_emu
// Emulates the serial output of an AD7276 ADC. Samples are pushed into a
// small buffer; each csn frame from the master shifts out LEAD_Z leading
// zeros, the sample MSB first, then zeros until csn rises. csn and sclk are
// synchronous to clk and oversampled by it.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   ad7276_csn           : frame select from master, active low
//   ad7276_sclk          : serial clock from master, idle high
//   ad7276_sdata         : serial data to master (updated 1 clk after sclk fall)
//   s_data/s_valid/s_ready : sample push handshake
//   frame_done           : pulse when the last data bit slot is entered
//   underrun             : pulse when a frame starts with the buffer empty
//   frame_abort          : pulse when csn rises before the last data bit
// Optional (macro AD7276_EMU_STATS_EN):
//   underrun_cnt, abort_cnt : saturating 8-bit event counters
// LEAD_Z must be at least 1.
// ----------------------------------------------------------------------------
module ad7276_emu
    import ad7276_pkg::*;
#(
    parameter int DATA_W = AD7276_DATA_W,
    parameter int LEAD_Z = AD7276_LEAD_Z,
    parameter int FIFO_D = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ad7276_csn,
    input  logic              ad7276_sclk,
    output logic              ad7276_sdata,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              frame_done,
    output logic              underrun,
    output logic              frame_abort
`ifdef AD7276_EMU_STATS_EN
    ,
    output logic [7:0]        underrun_cnt,
    output logic [7:0]        abort_cnt
`endif
);

    localparam int MAX_CNT = (DATA_W > LEAD_Z) ? DATA_W : LEAD_Z;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                csn_q;
    logic                sclk_q;
    logic                fall_sclk;
    logic                start;
    logic                frame_end;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   last;
    logic [DATA_W-1:0]   fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                load;
    logic                pop;

    // Edge detection on the master's lines
    assign fall_sclk = sclk_q & ~ad7276_sclk & ~ad7276_csn;
    assign start     = csn_q & ~ad7276_csn;
    assign frame_end = ~csn_q & ad7276_csn;

    // start and frame_end are mutually exclusive (csn is either low or high),
    // so end always wins; a start outside IDLE is ignored.
    assign load    = start & (state == IDLE);
    assign pop     = load & ~fifo_empty;
    assign s_ready = ~fifo_full;

    ad7276_emu_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_D)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s_valid),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Frame sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            csn_q        <= 1'b1;
            sclk_q       <= 1'b1;
            ad7276_sdata <= 1'b0;
            last         <= '0;
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
            frame_abort  <= 1'b0;
        end else begin
            csn_q       <= ad7276_csn;
            sclk_q      <= ad7276_sclk;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
            frame_abort <= 1'b0;
            if (frame_end) begin
                state        <= IDLE;
                cnt          <= '0;
                ad7276_sdata <= 1'b0;
                if (state == LEAD || state == DATA) frame_abort <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        ad7276_sdata <= 1'b0;
                        if (start) begin
                            // Slot 0 (a leading zero) is driven right away.
                            state <= (LEAD_Z > 1) ? LEAD : DATA;
                            cnt   <= '0;
                            if (fifo_empty) underrun <= 1'b1;
                            else            last     <= fifo_head;
                        end
                    end
                    LEAD: begin
                        if (fall_sclk) begin
                            ad7276_sdata <= 1'b0;
                            if (cnt == CNT_W'(LEAD_Z - 2)) begin
                                state <= DATA;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    DATA: begin
                        if (fall_sclk) begin
                            ad7276_sdata <= shreg[DATA_W-1];
                            if (cnt == CNT_W'(DATA_W - 1)) begin
                                state      <= TAIL;
                                cnt        <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    TAIL: begin
                        if (fall_sclk) ad7276_sdata <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Shift register: loaded at frame start (head, or last sample on
    // underrun), shifted MSB-first on each data slot.
    always_ff @(posedge clk) begin
        if (load)
            shreg <= fifo_empty ? last : fifo_head;
        else if (state == DATA && fall_sclk && !frame_end)
            shreg <= {shreg[DATA_W-2:0], 1'b0};
    end

`ifdef AD7276_EMU_STATS_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_cnt <= 8'd0;
            abort_cnt    <= 8'd0;
        end else begin
            if (underrun)    underrun_cnt <= sat_inc(underrun_cnt);
            if (frame_abort) abort_cnt    <= sat_inc(abort_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_ad7276_emu.sv
// ----------------------------------------------------------------------------
// tb_ad7276_emu
// Directed and randomized frames against a queue-based model of the
// emulator: samples in a queue, a remembered last sample, and a frame image
// of LEAD_Z zeros + sample MSB first + trailing zeros.
// Define AD7276_EMU_STATS_EN to also exercise the event counters.
// ----------------------------------------------------------------------------
module tb_ad7276_emu;
    import ad7276_pkg::*;

    localparam int DW = 12;
    localparam int LZ = 2;
    localparam int FD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          csn;
    logic          sclk;
    logic          sdata;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          frame_done;
    logic          underrun;
    logic          frame_abort;
`ifdef AD7276_EMU_STATS_EN
    logic [7:0]    underrun_cnt;
    logic [7:0]    abort_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_under = 0;
    int n_abort = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] mlast;

    always #5 clk = ~clk;

    ad7276_emu #(.DATA_W(DW), .LEAD_Z(LZ), .FIFO_D(FD)) dut (
        .clk          (clk),
        .rst          (rst),
        .ad7276_csn   (csn),
        .ad7276_sclk  (sclk),
        .ad7276_sdata (sdata),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .frame_done   (frame_done),
        .underrun     (underrun),
        .frame_abort  (frame_abort)
`ifdef AD7276_EMU_STATS_EN
        ,
        .underrun_cnt (underrun_cnt),
        .abort_cnt    (abort_cnt)
`endif
    );

    // Pulse tally, sampled mid-cycle so each one-cycle pulse is seen once.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done)  n_done++;
            if (underrun)    n_under++;
            if (frame_abort) n_abort++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected serial image: 2 leading zeros, sample MSB first, 2 tail zeros.
    function automatic logic [15:0] frame_bits(input logic [DW-1:0] s);
        return {2'b00, s, 2'b00};
    endfunction

    task automatic model_start(output logic [DW-1:0] s, output logic und);
        if (mq.size() == 0) begin
            s   = mlast;
            und = 1'b1;
        end else begin
            s     = mq.pop_front();
            mlast = s;
            und   = 1'b0;
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input string tag);
        @(negedge clk);
        s_data  = d;
        s_valid = 1'b1;
        chk(tag, s_ready, (mq.size() < FD));
        if (mq.size() < FD) mq.push_back(d);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // One master frame: nf sclk periods (clk/2), bits sampled on sclk high
    // just before each falling edge; bits[15] is the first slot.
    task automatic run_frame(input int nf, output logic [15:0] bits);
        bits = '0;
        @(negedge clk);
        csn = 1'b0;
        for (int i = 0; i < nf; i++) begin
            @(negedge clk);
            bits[15-i] = sdata;
            sclk = 1'b0;
            @(negedge clk);
            sclk = 1'b1;
        end
        @(negedge clk);
        csn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic full_frame(input string tag);
        logic [DW-1:0] s;
        logic          u;
        logic [15:0]   bits;
        int d0, u0, a0;
        d0 = n_done; u0 = n_under; a0 = n_abort;
        model_start(s, u);
        run_frame(FRAME_SCLK, bits);
        chk({tag, "_bits"},  bits, frame_bits(s));
        chk({tag, "_done"},  n_done - d0, 1);
        chk({tag, "_under"}, n_under - u0, u);
        chk({tag, "_abort"}, n_abort - a0, 0);
    endtask

    initial begin
        logic [DW-1:0] s, a, b;
        logic          u;
        logic [15:0]   bits, fb;
        int            d0, a0, np;

        rst = 1'b1; csn = 1'b1; sclk = 1'b1; s_valid = 1'b0; s_data = '0;
        mq.delete(); mlast = '0;
        repeat (3) @(negedge clk);
        chk("rst_sdata", sdata, 0);
        chk("rst_ready", s_ready, 1);
        chk("rst_done", frame_done, 0);
        chk("rst_under", underrun, 0);
        chk("rst_abort", frame_abort, 0);
`ifdef AD7276_EMU_STATS_EN
        chk("rst_ucnt", underrun_cnt, 0);
        chk("rst_acnt", abort_cnt, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Single known sample
        push(12'hA5C, "push_a5c");
        full_frame("f_a5c");

        // Underrun from reset, then resend of the last sample
        full_frame("und_zero");
        push(12'h123, "push_123");
        full_frame("f_123");
        full_frame("und_123");

        // Back-pressure when full; space frees on the next start
        push(12'h001, "push_1");
        push(12'h002, "push_2");
        @(negedge clk);
        s_data = 12'h003; s_valid = 1'b1;
        chk("full_ready", s_ready, 0);
        model_start(s, u);
        mq.push_back(12'h003);
        run_frame(FRAME_SCLK, bits);
        s_valid = 1'b0;
        chk("f_1_bits", bits, frame_bits(s));
        chk("refull_ready", s_ready, (mq.size() < FD));
        full_frame("f_2");
        full_frame("f_3");

        // Abort after 6 sclk falls; sample is consumed
        a = 12'($urandom); b = 12'($urandom);
        push(a, "push_ab_a");
        push(b, "push_ab_b");
        d0 = n_done; a0 = n_abort;
        model_start(s, u);
        run_frame(6, bits);
        fb = frame_bits(s);
        chk("abort_bits", bits[15:10], fb[15:10]);
        chk("abort_pulse", n_abort - a0, 1);
        chk("abort_nodone", n_done - d0, 0);
        full_frame("after_abort");

        // Reset in the middle of the data phase
        push(12'($urandom), "push_r0");
        push(12'($urandom), "push_r1");
        a0 = n_abort;
        @(negedge clk);
        csn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); sclk = 1'b0;
            @(negedge clk); sclk = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1; csn = 1'b1; sclk = 1'b1;
        #1;
        chk("midrst_sdata", sdata, 0);
        chk("midrst_ready", s_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete(); mlast = '0;
        repeat (2) @(negedge clk);
        chk("midrst_noabort", n_abort - a0, 0);
        full_frame("post_rst");

        // Randomized push counts and data
        for (int it = 0; it < 8; it++) begin
            np = int'($urandom_range(0, 3));
            for (int k = 0; k < np; k++) push(12'($urandom), "rnd_push");
            full_frame("rnd");
        end

`ifdef AD7276_EMU_STATS_EN
        // 300 short (aborted) frames, nearly all underrunning
        repeat (300) begin
            @(negedge clk); csn = 1'b0;
            @(negedge clk);
            @(negedge clk); csn = 1'b1;
        end
        repeat (2) @(negedge clk);
        chk("ucnt_sat", underrun_cnt, 8'd255);
        chk("acnt_sat", abort_cnt, 8'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad7276_emu.md
AD7276_EMU -- requirements
Module: ad7276_emu

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning sample width in bits.
REQ-002 SHALL have parameter LEAD_Z, default 2, meaning the number of leading-zero bit slots per frame.
REQ-003 SHALL have parameter FIFO_D, default 2, meaning the sample buffer depth (power of 2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; csn/sclk are generated from this same clock domain.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port ad7276_csn, input, 1 bit: frame select driven by the master, active low.
REQ-007 SHALL have port ad7276_sclk, input, 1 bit: serial clock driven by the master, idle high.
REQ-008 SHALL have port ad7276_sdata, output, 1 bit: serial data driven to the master.
REQ-009 SHALL have port s_data, input, DATA_W bits: the sample to be emulated.
REQ-010 SHALL have port s_valid, input, 1 bit, and port s_ready, output, 1 bit, forming a valid/ready push handshake.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a full frame completes.
REQ-012 SHALL have port underrun, output, 1 bit: one-cycle pulse when a frame starts with the buffer empty.
REQ-013 SHALL have port frame_abort, output, 1 bit: one-cycle pulse when csn rises before the last data bit.

Function
REQ-014 SHALL register csn and sclk once (csn_q, sclk_q); fall_sclk = sclk_q & ~sclk & ~csn; start = csn_q & ~csn; end = ~csn_q & csn.
REQ-015 SHALL implement FSM states IDLE, LEAD, DATA, TAIL: IDLE->LEAD on start; LEAD->DATA after LEAD_Z-1 fall_sclk; DATA->TAIL after DATA_W fall_sclk; any state->IDLE on end.
REQ-016 On start, SHALL pop the FIFO head into the shift register and drive sdata=0 on the next clk (first leading zero).
REQ-017 Each fall_sclk SHALL advance one bit slot, with sdata updated on the clk edge following detection (1-clk latency): leading zeros, then DB[DATA_W-1] down to DB0 MSB first, then 0 in TAIL.
REQ-018 In IDLE, sdata SHALL be 0.
REQ-019 frame_done SHALL pulse on the fall_sclk that leaves DATA; frame_abort SHALL pulse on end while in LEAD or DATA; end in TAIL is normal.
REQ-020 If the FIFO is empty at start, the block SHALL resend the last transmitted sample (0 after reset) and pulse underrun.
REQ-021 s_ready SHALL equal ~full; a push is accepted when s_valid & s_ready; a push and pop in the same cycle SHALL both take effect.
REQ-022 A start while not in IDLE (csn glitch without a seen end) SHALL be impossible by construction; a start in the same cycle as end SHALL be treated as end.
REQ-023 An aborted frame SHALL still consume its sample.

Reset
REQ-024 rst SHALL asynchronously force: state=IDLE, FIFO empty, s_ready=1, sdata=0, csn_q=1, sclk_q=1, last sample=0, all pulses=0.
REQ-025 Reset mid-frame SHALL discard the frame without pulsing frame_abort.

Configuration
REQ-026 With AD7276_EMU_STATS_EN defined, the block SHALL add outputs underrun_cnt[7:0] and abort_cnt[7:0], saturating at 255 and cleared by rst.
REQ-027 Without AD7276_EMU_STATS_EN, those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package ad7276_pkg SHALL hold the state typedef (IDLE/LEAD/DATA/TAIL), the defaults DATA_W=12 and LEAD_Z=2, and FRAME_SCLK=16.
REQ-029 The buffer SHALL be the sub-module ad7276_emu_fifo (synchronous FIFO, depth FIFO_D, with full/empty flags).

Verification
REQ-030 Push 0xA5C, then run one 16-sclk frame at sclk=clk/2 -> the bits sampled on sclk high are 0,0,1010_0101_1100,0,0, and frame_done pulses once.
REQ-031 No push, start frame -> underrun=1 for one cycle and data 0x000; then push 0x123 and run two frames -> 0x123, then 0x123 again with a second underrun.
REQ-032 Push 0x001, 0x002, then 0x003 -> s_ready=0 on the third; after the next start, 0x003 is accepted; the frames deliver 1, 2, 3 in order.
REQ-033 Raise csn after 6 sclk falls -> frame_abort pulse, no frame_done; the next frame sends the next FIFO entry.
REQ-034 Assert rst while in DATA -> sdata=0, state IDLE, FIFO empty, no abort pulse; the following frame underruns with 0x000.
REQ-035 With AD7276_EMU_STATS_EN, cause 300 underruns -> underrun_cnt=255.
